// File: rtl/pipe_stage_reg.sv
// Reusable inter-stage pipeline register with valid/ready handshake, optional
// two-entry skid buffer, synchronous flush and bubble-gated control bits.
module pipe_stage_reg #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 64,
    parameter int RD_W   = 5,
    parameter bit SKID   = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [CTRL_W-1:0] mainCtrl_p0, skidCtrl_p0;
    logic [DATA_W-1:0] mainData_p0, skidData_p0;
    logic [RD_W-1:0]   mainRd_p0,   skidRd_p0;
    logic              accept;
    logic              fire;

    // With the skid buffer, in_ready depends only on the state flop, so no
    // combinational path runs from out_ready back upstream.
    assign out_valid = (state != EMPTY);
    assign in_ready  = SKID ? (state != FULL) : (out_ready || !out_valid);
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign out_ctrl  = out_valid ? mainCtrl_p0 : '0;
    assign out_data  = mainData_p0;
    assign out_rd    = mainRd_p0;
    assign occupancy = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= EMPTY;
            mainCtrl_p0 <= '0;
            mainData_p0 <= '0;
            mainRd_p0   <= '0;
            skidCtrl_p0 <= '0;
            skidData_p0 <= '0;
            skidRd_p0   <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state       <= BUSY;
                        mainCtrl_p0 <= in_ctrl;
                        mainData_p0 <= in_data;
                        mainRd_p0   <= in_rd;
                    end
                end
                BUSY: begin
                    if (accept && fire) begin
                        mainCtrl_p0 <= in_ctrl;
                        mainData_p0 <= in_data;
                        mainRd_p0   <= in_rd;
                    end else if (accept) begin
                        // Only reachable with the skid buffer present.
                        state       <= FULL;
                        skidCtrl_p0 <= in_ctrl;
                        skidData_p0 <= in_data;
                        skidRd_p0   <= in_rd;
                    end else if (fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (fire) begin
                        state       <= BUSY;
                        mainCtrl_p0 <= skidCtrl_p0;
                        mainData_p0 <= skidData_p0;
                        mainRd_p0   <= skidRd_p0;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that generalises the fixed inter-stage latches (EX/MEM style) into one reusable block. It carries a control-bit vector, a data payload and a destination-register index from one stage to the next. A valid/ready handshake replaces free-running latching. An optional two-entry skid buffer lets back-pressure be registered without losing an instruction. Synchronous flush turns the stage into a bubble. It sits between any two pipeline stages (ID/EX, EX/MEM, MEM/WB).

## Interface
- CTRL_W, 9, width of control-bit vector
- DATA_W, 64, width of data payload (e.g. result + readData2 concatenated)
- RD_W, 5, width of destination-register index
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- clock  input  1  single clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream presents an instruction
- in_ready  output  1  stage accepts this cycle; accept = in_valid && in_ready
- in_ctrl  input  CTRL_W  control bits
- in_data  input  DATA_W  payload
- in_rd  input  RD_W  destination register
- flush  input  1  synchronous kill of all held entries
- out_valid  output  1  stage holds a valid instruction
- out_ready  input  1  downstream accepts; fire = out_valid && out_ready
- out_ctrl  output  CTRL_W  control bits, forced to 0 whenever out_valid = 0
- out_data  output  DATA_W  payload of head entry
- out_rd  output  RD_W  destination of head entry
- occupancy  output  2  entries held (0, 1, 2)

## Operation
- Storage: main entry (drives outputs) and, if SKID=1, skid entry. Each entry = {valid, ctrl, data, rd}.
- State machine (SKID=1): EMPTY, BUSY (main only), FULL (main + skid).
  - EMPTY: accept -> BUSY, main <= input.
  - BUSY: accept && fire -> BUSY, main <= input. Accept && !fire -> FULL, skid <= input. !accept && fire -> EMPTY. Otherwise hold.
  - FULL: in_ready = 0. Fire -> BUSY, main <= skid. Otherwise hold.
- SKID=0: states EMPTY and BUSY only; in_ready = out_ready || !out_valid (combinational).
- SKID=1: in_ready = (state != FULL), registered, with no combinational path from out_ready.
- Flush: highest priority. Next state = EMPTY and both valids cleared. An input presented with flush is dropped, even if in_ready = 1. out_ctrl reads 0 next cycle; data and rd registers may keep stale values.
- Ordering: strictly FIFO; skid entry never overtakes main.
- out_ctrl gated: out_ctrl = out_valid ? main.ctrl : 0. Downstream write enables (memRead, memWrite, regWrite) therefore cannot assert on a bubble.
- occupancy: EMPTY=0, BUSY=1, FULL=2.

## Timing
- Reset (reset_n low, asynchronous): state EMPTY, out_valid 0, out_ctrl 0, out_data 0, out_rd 0, occupancy 0, in_ready 1 (both modes), skid cleared.
- Latency: accepted at edge N -> visible on outputs after edge N, with out_valid = 1 in cycle N+1.
- Throughput: one instruction per cycle while out_ready = 1, in both modes.
- SKID=1 back-pressure: out_ready drop at cycle N is absorbed by the skid entry. in_ready falls the cycle after the skid fills and rises the cycle after the first fire from FULL.
- Simultaneous flush and fire: downstream sees the fire in that cycle, and the stage is EMPTY afterwards.
- Reset asserted mid-FULL: both entries discarded immediately, without waiting for a clock edge.
- Flush while EMPTY: no effect; in_ready stays 1.

## Test plan
- Stream: SKID=1, out_ready=1, in_valid=1 for 8 cycles with data 0..7 -> out_valid from cycle 1, out_data 0..7 in order on consecutive cycles, occupancy 1 throughout.
- Back-pressure: SKID=1, stream data 10,11,12 and drop out_ready at the cycle 11 is accepted -> skid holds 11, occupancy 2, in_ready 0. Raising out_ready emits 10, 11, 12 with no loss or duplication.
- Flush: stage FULL with ctrl 0x1FF in both entries; assert flush with in_valid=1 and data 99 -> next cycle out_valid 0, out_ctrl 0, occupancy 0, in_ready 1, and 99 never appears at the output.
- SKID=0: out_valid=1 and out_ready=0 -> in_ready 0 in the same cycle. out_ready=1 and in_valid=1 -> in_ready 1 and main replaced in one cycle.
- Async reset: assert reset_n=0 mid-cycle while FULL -> outputs go to reset values before the next edge. After release, a first accept with rd=5 gives out_rd=5 one cycle later.
- Bubble gating: hold in_valid=0 with in_ctrl=0x1FF -> out_ctrl stays 0 and out_valid stays 0 for all cycles.
